// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: multiplexed 7-segment refresh controller.
// Presents one {digit-select, segment} word per digit over valid/ready,
// then dwells a fixed number of cycles before presenting the next digit.
// Inputs are snapshotted when digit 0 is presented so a frame never tears.
module seg_digit_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 4096,
    parameter bit COMMON_ANODE   = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic [NUM_DIGITS-1:0]     i_blank,
    output logic [15:0]               o_word,
    output logic                      o_word_valid,
    input  logic                      i_word_ready,
    output logic [2:0]                o_digit_idx,
    output logic                      o_frame_start
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(REFRESH_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_START,
        ST_PRESENT,
        ST_DWELL
    } state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [2:0]    r_idx, w_idx_nx;
    logic [15:0]   r_word, w_word_nx;
    logic          r_fs, w_fs_nx;
    // Snapshots are zero-padded to the 8-digit maximum so indexing by a
    // 3-bit digit index is always in range.
    logic [31:0]   r_snap_value;
    logic [7:0]    r_snap_dp, r_snap_blank;
    logic          w_snap_en;
    logic          w_present;
    logic [2:0]    w_pres_idx;
    logic [2:0]    w_adv_idx;

    // Hex nibble to active-high segments, bit0=a .. bit6=g.
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'h3F;  4'h1: hex_seg = 8'h06;
            4'h2: hex_seg = 8'h5B;  4'h3: hex_seg = 8'h4F;
            4'h4: hex_seg = 8'h66;  4'h5: hex_seg = 8'h6D;
            4'h6: hex_seg = 8'h7D;  4'h7: hex_seg = 8'h07;
            4'h8: hex_seg = 8'h7F;  4'h9: hex_seg = 8'h6F;
            4'hA: hex_seg = 8'h77;  4'hB: hex_seg = 8'h7C;
            4'hC: hex_seg = 8'h39;  4'hD: hex_seg = 8'h5E;
            4'hE: hex_seg = 8'h79;  default: hex_seg = 8'h71;
        endcase
    endfunction

    // Full word for one digit: one-hot select, then segments with dp,
    // blanking, and finally polarity (blank therefore reads as all-off).
    function automatic logic [15:0] build_word(input logic [2:0] idx,
                                               input logic [3:0] nib,
                                               input logic dp,
                                               input logic blank);
        logic [7:0] seg;
        logic [7:0] sel;
        seg    = hex_seg(nib);
        seg[7] = dp;
        if (blank)
            seg = 8'h00;
        if (COMMON_ANODE)
            seg = ~seg;
        sel = 8'b1 << idx;
        build_word = {sel, seg};
    endfunction

    assign w_adv_idx = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;

    // Next-state, dwell counter and word selection.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_word_nx  = r_word;
        w_fs_nx    = 1'b0;
        w_snap_en  = 1'b0;
        w_present  = 1'b0;
        w_pres_idx = r_idx;
        case (r_state)
            ST_START: begin
                w_present  = 1'b1;
                w_pres_idx = 3'd0;
            end
            ST_PRESENT: begin
                if (i_word_ready) begin
                    w_cnt_nx   = CNT_LOAD;
                    w_state_nx = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (r_cnt == '0) begin
                    w_present  = 1'b1;
                    w_pres_idx = w_adv_idx;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = ST_START;
        endcase
        if (w_present) begin
            w_state_nx = ST_PRESENT;
            w_idx_nx   = w_pres_idx;
            if (w_pres_idx == 3'd0) begin
                // Digit 0 uses the live inputs being captured this edge.
                w_snap_en = 1'b1;
                w_fs_nx   = 1'b1;
                w_word_nx = build_word(3'd0, i_value[3:0], i_dp[0], i_blank[0]);
            end else begin
                w_word_nx = build_word(w_pres_idx,
                                       r_snap_value[{w_pres_idx, 2'b00} +: 4],
                                       r_snap_dp[w_pres_idx],
                                       r_snap_blank[w_pres_idx]);
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_word  <= 16'h0000;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_word  <= w_word_nx;
            r_fs    <= w_fs_nx;
        end
    end

    // Frame snapshot, refreshed only when digit 0 is presented.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_snap_value <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
        end else if (w_snap_en) begin
            r_snap_value <= 32'(i_value);
            r_snap_dp    <= 8'(i_dp);
            r_snap_blank <= 8'(i_blank);
        end
    end

    assign o_word        = r_word;
    assign o_word_valid  = (r_state == ST_PRESENT);
    assign o_digit_idx   = r_idx;
    assign o_frame_start = r_fs;

endmodule
